// File: rtl/writeback_pipe_stage_if.sv
// Upstream (memory-stage) to writeback-stage instruction handshake.
// The master drives the instruction fields; the slave returns mem_ready.
interface writeback_pipe_stage_if #(
   parameter int REG_AW = 5
);
   logic              mem_valid;
   logic              mem_ready;
   logic              mem_wen;
   logic [REG_AW-1:0] mem_regsrc;
   logic [31:0]       mem_result;
   logic              mem_is_load;
   logic [2:0]        mem_load_type;
   logic [1:0]        mem_addr_lo;

   modport master (
      output mem_valid, mem_wen, mem_regsrc, mem_result,
             mem_is_load, mem_load_type, mem_addr_lo,
      input  mem_ready
   );

   modport slave (
      input  mem_valid, mem_wen, mem_regsrc, mem_result,
             mem_is_load, mem_load_type, mem_addr_lo,
      output mem_ready
   );
endinterface

// File: rtl/writeback_pipe_stage.sv
// Writeback stage: captures an instruction, waits out the data-memory read
// latency for loads, extracts the load lane, and drives one register-file write.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no instruction held, ready to accept
// S_WAIT   | load accepted, counting down until dram_rdata is valid
// S_COMMIT | captured instruction presented on wb_*; may accept the next
module writeback_pipe_stage #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   writeback_pipe_stage_if.slave  mem,
   input  logic [31:0]            dram_rdata,
   output logic                   wb_wen,
   output logic [REG_AW-1:0]      wb_regsrc,
   output logic [31:0]            wb_regwdata,
   output logic                   wb_busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   localparam logic [2:0] CNT_INIT = (LOAD_LAT > 0) ? 3'(LOAD_LAT - 1) : 3'd0;
   localparam bit         HAS_WAIT = (LOAD_LAT > 0);

   state_t            state, state_nxt;
   logic [2:0]        cnt;
   logic              accept;
   logic              wait_done;

   logic              cap_wen;
   logic [REG_AW-1:0] cap_regsrc;
   logic [31:0]       cap_result;
   logic              cap_is_load;
   logic [2:0]        cap_load_type;
   logic [1:0]        cap_addr_lo;
   logic [31:0]       rdata_q;

   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;
   logic [31:0]       load_data;

   assign accept    = mem.mem_valid && mem.mem_ready;
   assign wait_done = (state == S_WAIT) && (cnt == 3'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      mem.mem_ready = 1'b1;
      case (state)
         S_IDLE, S_COMMIT: begin
            if (accept) begin
               state_nxt = (mem.mem_is_load && HAS_WAIT) ? S_WAIT : S_COMMIT;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            mem.mem_ready = 1'b0;
            if (cnt == 3'd0) begin
               state_nxt = S_COMMIT;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= 3'd0;
      end else if (accept && mem.mem_is_load && HAS_WAIT) begin
         cnt <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 3'd0) begin
         cnt <= cnt - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cap_wen       <= 1'b0;
         cap_regsrc    <= '0;
         cap_result    <= 32'd0;
         cap_is_load   <= 1'b0;
         cap_load_type <= 3'd0;
         cap_addr_lo   <= 2'd0;
      end else if (accept) begin
         cap_wen       <= mem.mem_wen;
         cap_regsrc    <= mem.mem_regsrc;
         cap_result    <= mem.mem_result;
         cap_is_load   <= mem.mem_is_load;
         cap_load_type <= mem.mem_load_type;
         cap_addr_lo   <= mem.mem_addr_lo;
      end
   end

   // With zero latency the read word is already valid at the accept edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q <= 32'd0;
      end else if (HAS_WAIT ? wait_done : (accept && mem.mem_is_load)) begin
         rdata_q <= dram_rdata;
      end
   end

   always_comb begin
      sel_byte = rdata_q[7:0];
      case (cap_addr_lo)
         2'd0:    sel_byte = rdata_q[7:0];
         2'd1:    sel_byte = rdata_q[15:8];
         2'd2:    sel_byte = rdata_q[23:16];
         default: sel_byte = rdata_q[31:24];
      endcase
      sel_half = cap_addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];

      load_data = rdata_q;
      case (cap_load_type)
         3'b001:  load_data = {{24{sel_byte[7]}}, sel_byte};
         3'b010:  load_data = {24'd0, sel_byte};
         3'b011:  load_data = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_data = {16'd0, sel_half};
         default: load_data = rdata_q;
      endcase
   end

   always_comb begin
      wb_wen      = 1'b0;
      wb_regsrc   = '0;
      wb_regwdata = 32'd0;
      wb_busy     = (state != S_IDLE);
      if (state == S_COMMIT) begin
         wb_wen      = cap_wen && (cap_regsrc != '0);
         wb_regsrc   = cap_regsrc;
         wb_regwdata = cap_is_load ? load_data : cap_result;
      end
   end

endmodule

// File: tb/tb_writeback_pipe_stage.sv
// Directed bench for writeback_pipe_stage with LOAD_LAT=2: ALU commits, load
// lane extraction, back-to-back throughput, r0 suppression and async reset.
module tb_writeback_pipe_stage;

   logic        clk;
   logic        resetn;
   logic [31:0] dram_rdata;
   logic        wb_wen;
   logic [4:0]  wb_regsrc;
   logic [31:0] wb_regwdata;
   logic        wb_busy;

   int checks = 0;
   int errors = 0;

   writeback_pipe_stage_if #(.REG_AW(5)) mem_bus ();

   writeback_pipe_stage #(.REG_AW(5), .LOAD_LAT(2)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .mem         (mem_bus),
      .dram_rdata  (dram_rdata),
      .wb_wen      (wb_wen),
      .wb_regsrc   (wb_regsrc),
      .wb_regwdata (wb_regwdata),
      .wb_busy     (wb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      mem_bus.mem_valid     = 1'b0;
      mem_bus.mem_wen       = 1'b0;
      mem_bus.mem_regsrc    = 5'd0;
      mem_bus.mem_result    = 32'd0;
      mem_bus.mem_is_load   = 1'b0;
      mem_bus.mem_load_type = 3'd0;
      mem_bus.mem_addr_lo   = 2'd0;
   endtask

   task automatic chk_out(input string name, input logic exp_wen, input logic [4:0] exp_rs,
                          input logic [31:0] exp_wd, input logic exp_busy, input logic exp_rdy);
      checks++;
      if (wb_wen !== exp_wen || wb_regsrc !== exp_rs || wb_regwdata !== exp_wd ||
          wb_busy !== exp_busy || mem_bus.mem_ready !== exp_rdy) begin
         errors++;
         $display("FAIL %s: got wen=%b rs=%0d wd=%h busy=%b rdy=%b, expected wen=%b rs=%0d wd=%h busy=%b rdy=%b",
                  name, wb_wen, wb_regsrc, wb_regwdata, wb_busy, mem_bus.mem_ready,
                  exp_wen, exp_rs, exp_wd, exp_busy, exp_rdy);
      end
   endtask

   task automatic drive_alu(input logic wen, input logic [4:0] rs, input logic [31:0] res);
      mem_bus.mem_valid   = 1'b1;
      mem_bus.mem_wen     = wen;
      mem_bus.mem_regsrc  = rs;
      mem_bus.mem_result  = res;
      mem_bus.mem_is_load = 1'b0;
   endtask

   task automatic test_reset();
      resetn     = 1'b0;
      dram_rdata = 32'd0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk_out("reset_state", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      resetn = 1'b1;
      @(negedge clk);
      chk_out("after_release", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic test_alu();
      @(negedge clk);
      drive_alu(1'b1, 5'd5, 32'h1234_5678);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk_out("alu_commit", 1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b1);
      @(negedge clk);
      chk_out("alu_after", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic test_load(input string name, input logic [2:0] ltype, input logic [1:0] addr,
                            input logic [31:0] word, input logic [31:0] exp);
      @(negedge clk);
      mem_bus.mem_valid     = 1'b1;
      mem_bus.mem_wen       = 1'b1;
      mem_bus.mem_regsrc    = 5'd7;
      mem_bus.mem_result    = 32'hFACE_0000;
      mem_bus.mem_is_load   = 1'b1;
      mem_bus.mem_load_type = ltype;
      mem_bus.mem_addr_lo   = addr;
      dram_rdata            = 32'hDEAD_0000;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk_out({name, "_wait1"}, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      dram_rdata = word;
      chk_out({name, "_wait2"}, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      dram_rdata = 32'h5555_5555;
      chk_out({name, "_commit"}, 1'b1, 5'd7, exp, 1'b1, 1'b1);
      @(negedge clk);
      chk_out({name, "_after"}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [4:0]  rs_tab [4];
      logic [31:0] wd_tab [4];
      rs_tab = '{5'd1, 5'd2, 5'd3, 5'd31};
      wd_tab = '{32'h0000_0001, 32'hAAAA_5555, 32'h8000_0000, 32'hFFFF_FFFF};
      @(negedge clk);
      drive_alu(1'b1, rs_tab[0], wd_tab[0]);
      @(posedge clk);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk_out($sformatf("b2b_%0d", i - 1), 1'b1, rs_tab[i-1], wd_tab[i-1], 1'b1, 1'b1);
         drive_alu(1'b1, rs_tab[i], wd_tab[i]);
         @(posedge clk);
      end
      @(negedge clk);
      chk_out("b2b_3", 1'b1, rs_tab[3], wd_tab[3], 1'b1, 1'b1);
      idle_inputs();
      @(negedge clk);
      chk_out("b2b_drain", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic test_no_write();
      @(negedge clk);
      drive_alu(1'b1, 5'd0, 32'h0BAD_F00D);
      @(posedge clk);
      @(negedge clk);
      drive_alu(1'b0, 5'd3, 32'h0000_0033);
      chk_out("r0_suppressed", 1'b0, 5'd0, 32'h0BAD_F00D, 1'b1, 1'b1);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk_out("wen0_commit", 1'b0, 5'd3, 32'h0000_0033, 1'b1, 1'b1);
      @(negedge clk);
      chk_out("no_write_idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_wait();
      int wen_seen;
      @(negedge clk);
      mem_bus.mem_valid     = 1'b1;
      mem_bus.mem_wen       = 1'b1;
      mem_bus.mem_regsrc    = 5'd12;
      mem_bus.mem_is_load   = 1'b1;
      mem_bus.mem_load_type = 3'b000;
      dram_rdata            = 32'hCAFE_BABE;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk_out("rst_pre_wait", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      #2 resetn = 1'b0;
      #1 chk_out("rst_async", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      resetn   = 1'b1;
      wen_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (wb_wen === 1'b1 || wb_busy === 1'b1) wen_seen++;
      end
      checks++;
      if (wen_seen !== 0) begin
         errors++;
         $display("FAIL rst_abandon: got %0d active cycles, expected 0", wen_seen);
      end
      drive_alu(1'b1, 5'd9, 32'h0000_0099);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk_out("rst_recover", 1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b1);
      @(negedge clk);
      chk_out("rst_recover_after", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load("lb_lane3",   3'b001, 2'd3, 32'h80AA_BBCC, 32'hFFFF_FF80);
      test_load("lbu_lane1",  3'b010, 2'd1, 32'h80AA_BBCC, 32'h0000_00BB);
      test_load("lb_lane0",   3'b001, 2'd0, 32'h0000_007F, 32'h0000_007F);
      test_load("lhu_hi",     3'b100, 2'd2, 32'h9ABC_1234, 32'h0000_9ABC);
      test_load("lh_lo",      3'b011, 2'd0, 32'h0000_8001, 32'hFFFF_8001);
      test_load("lh_odd_hi",  3'b011, 2'd3, 32'h7FFF_0000, 32'h0000_7FFF);
      test_load("lw",         3'b000, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      test_load("lw_default", 3'b111, 2'd2, 32'h1357_9BDF, 32'h1357_9BDF);
      test_back_to_back();
      test_no_write();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
